// File: rtl/xorshift_pkg.sv
// Shared constants and types for the multi-channel xorshift generator.
package xorshift_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } gen_state_t;

  // Shift triples (A, B, C) for x ^= x<<A; x ^= x>>B; x ^= x<<C.
  localparam int A32 = 13;
  localparam int B32 = 17;
  localparam int C32 = 5;
  localparam int A64 = 13;
  localparam int B64 = 7;
  localparam int C64 = 17;

endpackage

// File: rtl/xorshift_step.sv
// Purely combinational single xorshift step for a WIDTH-bit state.
module xorshift_step
  import xorshift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  localparam int SA = (WIDTH == 64) ? A64 : A32;
  localparam int SB = (WIDTH == 64) ? B64 : B32;
  localparam int SC = (WIDTH == 64) ? C64 : C32;

  logic [WIDTH-1:0] t1;
  logic [WIDTH-1:0] t2;

  assign t1  = cur ^ (cur << SA);
  assign t2  = t1 ^ (t1 >> SB);
  assign nxt = t2 ^ (t2 << SC);

endmodule

// File: rtl/xorshift_gen.sv
// Round-robin multi-channel xorshift generator with valid/ready output and seed loading.
module xorshift_gen
  import xorshift_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               CHANNELS = 4,
  parameter logic [WIDTH-1:0] SEED     = 1,
  localparam int              CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seed_valid,
  input  logic [CW-1:0]    seed_chan,
  input  logic [WIDTH-1:0] seed_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    dchan,
  output logic [31:0]      count
);

  if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("xorshift_gen: WIDTH must be 32 or 64");
  end
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("xorshift_gen: CHANNELS must be in 1..8");
  end

  // A zero state is a fixed point of xorshift, so it is never stored.
  function automatic logic [WIDTH-1:0] nonzero(input logic [WIDTH-1:0] x);
    return (x == '0) ? WIDTH'(1) : x;
  endfunction

  gen_state_t       fsm;
  gen_state_t       fsm_next;
  logic [WIDTH-1:0] state [CHANNELS];
  logic [CW-1:0]    ptr;
  logic [WIDTH-1:0] step_out;
  logic             handshake;
  logic             seed_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) fsm <= INIT;
    else       fsm <= fsm_next;
  end

  always_comb begin
    fsm_next  = fsm;
    out_valid = 1'b0;
    case (fsm)
      INIT: fsm_next = RUN;
      RUN:  out_valid = 1'b1;
      default: fsm_next = INIT;
    endcase
  end

  assign handshake = out_valid && out_ready;
  assign seed_hit  = seed_valid && (32'(seed_chan) < CHANNELS);

  xorshift_step #(.WIDTH(WIDTH)) u_step (
    .cur (state[ptr]),
    .nxt (step_out)
  );

  // NOTE: the state array is reset explicitly because every channel has a
  // defined reset seed; a memory without reset would start as X here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state[i] <= nonzero(SEED + WIDTH'(i));
      end
    end else begin
      if (handshake) begin
        state[ptr] <= step_out;
        ptr        <= (ptr == CW'(CHANNELS - 1)) ? '0 : ptr + 1'b1;
        count      <= count + 32'd1;
      end
      // Placed after the step update so a seed to the same channel wins.
      if (seed_hit) state[seed_chan] <= nonzero(seed_data);
    end
  end

  assign dout  = state[ptr];
  assign dchan = ptr;

  a_valid_nonzero : assert property (@(posedge clock) disable iff (reset)
    out_valid |-> dout != '0);

endmodule

// File: tb/tb_xorshift_gen.sv
// Self-checking bench: behavioural model for the 32-bit/4-channel instance plus literal vectors.
module tb_xorshift_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        seed_valid;
  logic [1:0]  seed_chan;
  logic [31:0] seed_data;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] dout;
  logic [1:0]  dchan;
  logic [31:0] count;

  // Single-channel instances (32 and 64 bit) share a ready line.
  logic        rdy_s;
  logic        s1_valid;
  logic [0:0]  s1_chan;
  logic [31:0] s1_data;
  logic        v1, v2;
  logic [31:0] dout1;
  logic [63:0] dout2;
  logic [0:0]  dchan1, dchan2;
  logic [31:0] count1, count2;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  xorshift_gen #(.WIDTH(32), .CHANNELS(4), .SEED(32'd1)) dut (
    .clock(clock), .reset(reset), .seed_valid(seed_valid), .seed_chan(seed_chan),
    .seed_data(seed_data), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .dchan(dchan), .count(count)
  );

  xorshift_gen #(.WIDTH(32), .CHANNELS(1), .SEED(32'd1)) dut1 (
    .clock(clock), .reset(reset), .seed_valid(s1_valid), .seed_chan(s1_chan),
    .seed_data(s1_data), .out_valid(v1), .out_ready(rdy_s),
    .dout(dout1), .dchan(dchan1), .count(count1)
  );

  xorshift_gen #(.WIDTH(64), .CHANNELS(1), .SEED(64'd1)) dut2 (
    .clock(clock), .reset(reset), .seed_valid(1'b0), .seed_chan(1'b0),
    .seed_data(64'd0), .out_valid(v2), .out_ready(rdy_s),
    .dout(dout2), .dchan(dchan2), .count(count2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] xs32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Behavioural model of the 4-channel instance.
  logic [31:0] m_state [4];
  int          m_ptr;
  logic [31:0] m_count;
  logic        m_run;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m_state[i] <= 32'd1 + 32'(i);
      m_ptr   <= 0;
      m_count <= 0;
      m_run   <= 1'b0;
    end else begin
      if (m_run && out_ready) begin
        m_state[m_ptr] <= xs32(m_state[m_ptr]);
        m_ptr          <= (m_ptr + 1) % 4;
        m_count        <= m_count + 1;
      end
      if (seed_valid) m_state[seed_chan] <= (seed_data == 0) ? 32'd1 : seed_data;
      m_run <= 1'b1;
    end
  end

  always @(negedge clock) begin
    check("cmp_valid", 64'(out_valid), 64'(m_run));
    check("cmp_dout",  64'(dout),      64'(m_state[m_ptr]));
    check("cmp_dchan", 64'(dchan),     64'(m_ptr));
    check("cmp_count", 64'(count),     64'(m_count));
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic expect0(input string tag, input logic [31:0] d, input logic [1:0] c,
                         input logic [31:0] n);
    check({tag, "_dout"},  64'(dout),  64'(d));
    check({tag, "_dchan"}, 64'(dchan), 64'(c));
    check({tag, "_count"}, 64'(count), 64'(n));
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  logic [31:0] vec_dout [5] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h0004_2021};

  initial begin
    reset = 1'b0; seed_valid = 0; seed_chan = 0; seed_data = 0; out_ready = 0;
    rdy_s = 1; s1_valid = 0; s1_chan = 0; s1_data = 0;
    #1 reset = 1'b1;
    repeat (2) cyc();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_dout",  64'(dout),      64'd1);
    check("rst_dchan", 64'(dchan),     64'd0);
    check("rst_count", 64'(count),     64'd0);

    reset = 1'b0;
    out_ready = 1'b1;
    #1 check("init_valid", 64'(out_valid), 64'd0);
    cyc();

    // Free-running handshakes: round robin over the reset seeds, then wrap.
    for (int i = 0; i < 5; i++) begin
      expect0($sformatf("rr%0d", i), vec_dout[i], 2'(i % 4), 32'(i));
      if (i == 0) begin
        check("ch1_first", 64'(dout1), 64'h1);
        check("w64_first", dout2, 64'h1);
      end
      if (i == 1) begin
        check("ch1_second", 64'(dout1), 64'h0004_2021);
        check("w64_second", dout2, 64'h0000_0000_4082_2041);
      end
      if (i == 2) begin
        check("ch1_count", 64'(count1), 64'd2);
        check("w64_count", 64'(count2), 64'd2);
        check("ch1_dchan", 64'(dchan1), 64'd0);
        rdy_s = 1'b0;
      end
      if (i < 4) cyc();
    end

    // Back-pressure: nothing moves for five cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      expect0("stall", 32'h0004_2021, 2'd0, 32'd4);
    end

    // Out-of-range seed channel on the single-channel instance is ignored.
    s1_valid = 1'b1; s1_chan = 1'b1; s1_data = 32'd5;
    cyc();
    check("ch1_ignore", 64'(dout1), 64'(xs32(32'h0004_2021)));
    s1_chan = 1'b0; s1_data = 32'd0;
    cyc();
    s1_valid = 1'b0;
    check("ch1_zero_seed", 64'(dout1), 64'd1);

    // Zero seed on the current channel together with a handshake.
    out_ready = 1'b1; seed_valid = 1'b1; seed_chan = 2'd0; seed_data = 32'd0;
    cyc();
    seed_valid = 1'b0;
    check("zs_dchan", 64'(dchan), 64'd1);
    check("zs_count", 64'(count), 64'd5);
    repeat (3) cyc();
    expect0("zs_back", 32'd1, 2'd0, 32'd8);

    // Seed on a different channel while channel 0 is accepted.
    seed_valid = 1'b1; seed_chan = 2'd2; seed_data = 32'hDEAD_BEEF;
    cyc();
    seed_valid = 1'b0;
    cyc();
    expect0("xseed", 32'hDEAD_BEEF, 2'd2, 32'd10);

    // Mixed traffic, checked against the model every cycle.
    for (int i = 0; i < 40; i++) begin
      out_ready  = (i % 3 != 0);
      seed_valid = (i % 7 == 3);
      seed_chan  = 2'(i % 4);
      seed_data  = (i == 10) ? 32'd0 : 32'(i) * 32'h0123_4567;
      cyc();
    end
    seed_valid = 1'b0;

    // Asynchronous reset between edges with pending seed/handshake.
    out_ready = 1'b1; seed_valid = 1'b1; seed_chan = 2'd3; seed_data = 32'd9;
    #3 reset = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count),     64'd0);
    check("arst_dchan", 64'(dchan),     64'd0);
    check("arst_dout",  64'(dout),      64'd1);
    cyc();
    reset = 1'b0; seed_data = 32'd7;
    #1 check("arel_valid", 64'(out_valid), 64'd0);
    cyc();
    seed_valid = 1'b0;
    check("arel_run", 64'(out_valid), 64'd1);
    repeat (3) cyc();
    expect0("init_seed", 32'd7, 2'd3, 32'd3);

    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
